// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// With SERIAL_SUB_OVERFLOW_EN defined the bundle also carries the signed-overflow flag ovf.
interface serial_subtractor_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic             bit_valid;
   logic             a;
   logic             b;
   logic             busy;
   logic             diff_bit;
   logic             diff_bit_valid;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;
   logic             done;
`ifdef SERIAL_SUB_OVERFLOW_EN
   logic             ovf;
`endif

   modport master (
      output start, bit_valid, a, b,
      input  busy, diff_bit, diff_bit_valid, diff, borrow_out, done
`ifdef SERIAL_SUB_OVERFLOW_EN
      , ovf
`endif
   );

   modport slave (
      input  start, bit_valid, a, b,
      output busy, diff_bit, diff_bit_valid, diff, borrow_out, done
`ifdef SERIAL_SUB_OVERFLOW_EN
      , ovf
`endif
   );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first two's-complement subtractor (A - B) with parallel result and borrow-out.
// Optional SERIAL_SUB_OVERFLOW_EN adds a signed-overflow output (ovf).
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   serial_subtractor_if.slave bus
);
   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             borrow_q, borrow_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             diff_bit_q, diff_bit_d;
   logic             dbv_q, dbv_d;
   logic             borrow_out_q, borrow_out_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             ovf_q, ovf_d;

   logic accept, last, d_bit, borrow_nx;

   assign accept    = (state_q == S_RUN) && bus.bit_valid;
   assign last      = (cnt_q == CNT_W'(WIDTH - 1));
   assign d_bit     = bus.a ^ bus.b ^ borrow_q;
   assign borrow_nx = (~bus.a & bus.b) | (~(bus.a ^ bus.b) & borrow_q);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (bus.start)     state_d = S_RUN;
         S_RUN:   if (accept && last) state_d = S_DONE;
         S_DONE:                      state_d = S_IDLE;
         default:                     state_d = S_IDLE;
      endcase
   end

   // Output / datapath next values
   always_comb begin
      cnt_d        = cnt_q;
      borrow_d     = borrow_q;
      diff_d       = diff_q;
      diff_bit_d   = diff_bit_q;
      dbv_d        = 1'b0;
      borrow_out_d = borrow_out_q;
      ovf_d        = ovf_q;
      busy_d       = (state_d == S_RUN);
      done_d       = (state_d == S_DONE);
      if (state_q == S_IDLE && bus.start) begin
         cnt_d    = '0;
         borrow_d = 1'b0;
         diff_d   = '0;
      end
      if (accept) begin
         diff_d     = {d_bit, diff_q[WIDTH-1:1]};
         diff_bit_d = d_bit;
         dbv_d      = 1'b1;
         cnt_d      = cnt_q + CNT_W'(1);
         borrow_d   = borrow_nx;
         if (last) begin
            borrow_out_d = borrow_nx;
            // Overflow: borrow into the MSB differs from borrow out of it
            ovf_d        = borrow_q ^ borrow_nx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q        <= '0;
         borrow_q     <= 1'b0;
         diff_q       <= '0;
         diff_bit_q   <= 1'b0;
         dbv_q        <= 1'b0;
         borrow_out_q <= 1'b0;
         ovf_q        <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         borrow_q     <= borrow_d;
         diff_q       <= diff_d;
         diff_bit_q   <= diff_bit_d;
         dbv_q        <= dbv_d;
         borrow_out_q <= borrow_out_d;
         ovf_q        <= ovf_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign bus.busy           = busy_q;
   assign bus.diff_bit       = diff_bit_q;
   assign bus.diff_bit_valid = dbv_q;
   assign bus.diff           = diff_q;
   assign bus.borrow_out     = borrow_out_q;
   assign bus.done           = done_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
   assign bus.ovf            = ovf_q;
`else
   logic unused_ovf;
   assign unused_ovf = ovf_q;
`endif
endmodule
